falafel_fifo_reader: RTL and testbench

Read-side companion of the falafel internal FIFO: pops words from the FIFO's show-ahead read port (empty flag, head data, read strobe) and presents them as a valid/ready stream to a downstream consumer. A two-entry output buffer decouples downstream backpressure from the FIFO read strobe, so no combinational path runs from `out_ready_i` to `fifo_read_o`. The block sits between the FIFO and any stream sink, such as the allocator response path.

---
 rtl/falafel_fifo_reader.sv | 46 ++++
 tb/tb_falafel_fifo_reader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/falafel_fifo_reader.sv
// falafel_fifo_reader: pops a show-ahead FIFO into a two-slot valid/ready buffer; FALAFEL_FIFO_READER_STATS_EN adds the pop counter
module falafel_fifo_reader #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              flush_i,
  input  logic              fifo_empty_i,
  input  logic [DATA_W-1:0] fifo_dout_i,
  output logic              fifo_read_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CNT_W-1:0]  pop_cnt_o
);
  logic [1:0]        cnt;
  logic [DATA_W-1:0] slot0, slot1;
  logic              pop;
  assign fifo_read_o = enable_i && !fifo_empty_i && cnt != 2'd2 && !flush_i && !rst_i;
  assign out_valid_o = cnt != 2'd0;
  assign out_data_o  = slot0;
  assign pop         = out_valid_o && out_ready_i;
  always_ff @(posedge clk_i)
    if (rst_i) begin
      cnt   <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      cnt <= flush_i ? 2'd0 : cnt + {1'b0, fifo_read_o} - {1'b0, pop};
      if (fifo_read_o && (cnt == 2'd0 || (cnt == 2'd1 && pop)))
        slot0 <= fifo_dout_i;
      else if (cnt == 2'd2 && pop)
        slot0 <= slot1;
      if (fifo_read_o && cnt == 2'd1 && !pop)
        slot1 <= fifo_dout_i;
    end
`ifdef FALAFEL_FIFO_READER_STATS_EN
  always_ff @(posedge clk_i)
    if (rst_i) pop_cnt_o <= '0;
    else if (fifo_read_o) pop_cnt_o <= pop_cnt_o + 1'b1;
`else
  assign pop_cnt_o = '0;
`endif
endmodule

// File: tb/tb_falafel_fifo_reader.sv
// tb_falafel_fifo_reader: directed self-checking bench for falafel_fifo_reader
module tb_falafel_fifo_reader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic        flush = 1'b0;
  logic        fifo_empty;
  logic [15:0] fifo_dout;
  logic        fifo_read;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic [3:0]  pop_cnt;
  logic [15:0] mem [64];
  int          rd = 0;
  int          wr = 0;
  int          checks = 0;
  int          errors = 0;
  logic [3:0]  exp_wrap;
  always #5 clk = ~clk;
  assign fifo_empty = rd == wr;
  assign fifo_dout  = mem[rd % 64];
  always @(posedge clk) if (fifo_read) rd <= rd + 1;
  falafel_fifo_reader #(.DATA_W(16), .CNT_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .flush_i(flush),
    .fifo_empty_i(fifo_empty), .fifo_dout_i(fifo_dout), .fifo_read_o(fifo_read),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .pop_cnt_o(pop_cnt)
  );
  task automatic load(input logic [15:0] w);
    mem[wr % 64] = w;
    wr++;
  endtask
  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 1; i <= 5; i++) load(16'(i));
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++;
    if (out_data !== 16'h0) begin errors++; $display("FAIL reset_data got %h exp 0000", out_data); end
    checks++;
    if (fifo_read !== 1'b0) begin errors++; $display("FAIL reset_read got %b exp 0", fifo_read); end
    checks++;
    if (pop_cnt !== 4'd0) begin errors++; $display("FAIL reset_popcnt got %0d exp 0", pop_cnt); end
  endtask
  task automatic test_stream;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (fifo_read !== (i < 5)) begin errors++; $display("FAIL stream_read[%0d] got %b exp %b", i, fifo_read, i < 5); end
      checks++;
      if (out_valid !== (i >= 1 && i <= 5)) begin errors++; $display("FAIL stream_valid[%0d] got %b exp %b", i, out_valid, i >= 1 && i <= 5); end
      if (i >= 1 && i <= 5) begin
        checks++;
        if (out_data !== 16'(i)) begin errors++; $display("FAIL stream_data[%0d] got %h exp %h", i, out_data, 16'(i)); end
      end
    end
  endtask
  task automatic test_backpressure;
    logic [15:0] exp_d [5];
    logic        exp_r [5];
    exp_d = '{16'h10, 16'h11, 16'h12, 16'h13, 16'h0};
    exp_r = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) load(16'h10 + 16'(i));
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++;
      if (fifo_read !== (i < 2)) begin errors++; $display("FAIL bp_read[%0d] got %b exp %b", i, fifo_read, i < 2); end
      if (i >= 1) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h10) begin errors++; $display("FAIL bp_head[%0d] got %b/%h exp 1/0010", i, out_valid, out_data); end
      end
    end
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      checks++;
      if (out_valid !== (j < 4)) begin errors++; $display("FAIL bp_drain_valid[%0d] got %b exp %b", j, out_valid, j < 4); end
      if (j < 4) begin
        checks++;
        if (out_data !== exp_d[j]) begin errors++; $display("FAIL bp_drain_data[%0d] got %h exp %h", j, out_data, exp_d[j]); end
      end
      checks++;
      if (fifo_read !== exp_r[j]) begin errors++; $display("FAIL bp_drain_read[%0d] got %b exp %b", j, fifo_read, exp_r[j]); end
    end
  endtask
  task automatic test_flush;
    @(negedge clk);
    out_ready = 1'b0;
    load(16'hAAAA);
    load(16'hBBBB);
    load(16'hCCCC);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'hAAAA || fifo_read !== 1'b0) begin errors++; $display("FAIL flush_pre got %b/%h/%b exp 1/aaaa/0", out_valid, out_data, fifo_read); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", out_valid); end
    checks++;
    if (fifo_read !== 1'b1) begin errors++; $display("FAIL flush_repop got %b exp 1", fifo_read); end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'hCCCC) begin errors++; $display("FAIL flush_next got %b/%h exp 1/cccc", out_valid, out_data); end
    out_ready = 1'b1;
    @(negedge clk);
    load(16'hDDDD);
    flush = 1'b1;
    #1;
    checks++;
    if (fifo_read !== 1'b0) begin errors++; $display("FAIL flush_blocks_pop got %b exp 0", fifo_read); end
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || fifo_read !== 1'b1) begin errors++; $display("FAIL flush_after got %b/%b exp 0/1", out_valid, fifo_read); end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'hDDDD) begin errors++; $display("FAIL flush_dddd got %b/%h exp 1/dddd", out_valid, out_data); end
    @(negedge clk);
  endtask
  task automatic test_enable;
    @(negedge clk);
    enable = 1'b0;
    load(16'h20);
    load(16'h21);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (fifo_read !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL en_gated[%0d] got %b/%b exp 0/0", i, fifo_read, out_valid); end
    end
    enable = 1'b1;
    #1;
    checks++;
    if (fifo_read !== 1'b1) begin errors++; $display("FAIL en_rise got %b exp 1", fifo_read); end
    @(negedge clk);
    enable = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h20 || fifo_read !== 1'b0) begin errors++; $display("FAIL en_drain got %b/%h/%b exp 1/0020/0", out_valid, out_data, fifo_read); end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || fifo_empty !== 1'b0) begin errors++; $display("FAIL en_hold got %b/%b exp 0/0", out_valid, fifo_empty); end
    enable = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h21) begin errors++; $display("FAIL en_resume got %b/%h exp 1/0021", out_valid, out_data); end
    @(negedge clk);
  endtask
  task automatic test_reset_mid;
    @(negedge clk);
    out_ready = 1'b0;
    load(16'h30);
    load(16'h31);
    load(16'h32);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h30) begin errors++; $display("FAIL rmid_pre got %b/%h exp 1/0030", out_valid, out_data); end
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0 || fifo_read !== 1'b0 || pop_cnt !== 4'd0) begin errors++; $display("FAIL rmid_outs got %b/%h/%b/%0d exp 0/0000/0/0", out_valid, out_data, fifo_read, pop_cnt); end
    rst = 1'b0;
    #1;
    checks++;
    if (fifo_read !== 1'b1) begin errors++; $display("FAIL rmid_firstpop got %b exp 1", fifo_read); end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h32) begin errors++; $display("FAIL rmid_word got %b/%h exp 1/0032", out_valid, out_data); end
    @(negedge clk);
  endtask
  task automatic test_stats_wrap;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 17; i++) load(16'h100 + 16'(i));
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    #1;
`ifdef FALAFEL_FIFO_READER_STATS_EN
    exp_wrap = 4'd1;
`else
    exp_wrap = 4'd0;
`endif
    checks++;
    if (pop_cnt !== exp_wrap) begin errors++; $display("FAIL stats_wrap got %0d exp %0d", pop_cnt, exp_wrap); end
    checks++;
    if (fifo_empty !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL stats_drained got %b/%b exp 1/0", fifo_empty, out_valid); end
  endtask
  initial begin
    test_reset;
    test_stream;
    test_backpressure;
    test_flush;
    test_enable;
    test_reset_mid;
    test_stats_wrap;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
